// File: rtl/lcplc_pkg.sv
// Shared helpers for the LCPLC predictor datapath stages
// (block_mean_calc, alpha_calc and the planned xhatmean stage).
package lcplc_pkg;

  // Accumulator width for a block of 2^blk_log samples of data_w bits.
  // The sum of N full-scale samples never exceeds this width.
  function automatic int acc_width(input int data_w, input int blk_log);
    return data_w + blk_log;
  endfunction

  // Half an LSB of the block mean, added before the shift to get
  // round-half-up division by 2^blk_log.
  function automatic int round_offset(input int blk_log);
    return 1 << (blk_log - 1);
  endfunction

endpackage

// File: rtl/block_mean_calc_if.sv
// Stream bundle for block_mean_calc: sample input stream plus block mean
// output stream.
//
// Handshake semantics (both streams): a beat transfers on a rising clock
// edge where valid && ready. A source holds valid and data stable until the
// beat transfers. On the sample stream, ready may depend combinationally on
// the mean stream's ready; no other path through the block is combinational.
interface block_mean_calc_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  x_valid;
  logic                  x_ready;
  logic [DATA_WIDTH-1:0] x_data;
  logic                  xmean_valid;
  logic                  xmean_ready;
  logic [DATA_WIDTH-1:0] xmean_data;

  // Block side: consumes samples, produces means.
  modport slave (
    input  x_valid,
    input  x_data,
    input  xmean_ready,
    output x_ready,
    output xmean_valid,
    output xmean_data
  );

  // Environment side: produces samples, consumes means.
  modport master (
    output x_valid,
    output x_data,
    output xmean_ready,
    input  x_ready,
    input  xmean_valid,
    input  xmean_data
  );

endinterface

// File: rtl/block_mean_calc.sv
// Block mean of an unsigned sample stream: accumulates 2^BLOCK_SIZE_LOG
// samples and emits one round-half-up mean per block. Accumulation of the
// next block overlaps with the wait for the previous mean to be taken; only
// the final sample of a block stalls while an untaken mean is held.
module block_mean_calc
  import lcplc_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int BLOCK_SIZE_LOG = 8
) (
  input  logic                clk,
  input  logic                rst,
  block_mean_calc_if.slave    bus
);

  localparam int                        ACC_WIDTH = acc_width(DATA_WIDTH, BLOCK_SIZE_LOG);
  localparam logic [BLOCK_SIZE_LOG-1:0] CNT_LAST  = '1;
  localparam logic [ACC_WIDTH-1:0]      ROUND_OFS = ACC_WIDTH'(round_offset(BLOCK_SIZE_LOG));

  logic [BLOCK_SIZE_LOG-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]      acc_q, acc_d;
  logic                      xmean_valid_q, xmean_valid_d;
  logic [DATA_WIDTH-1:0]     xmean_data_q, xmean_data_d;

  logic                      at_last;
  logic                      x_ready;
  logic                      accept;
  logic                      last_accept;
  logic [ACC_WIDTH-1:0]      sum_last;
  logic [DATA_WIDTH-1:0]     mean_w;

  // Stall only the closing sample of a block while a mean is still untaken;
  // a take in the same cycle frees the output register, hence the
  // combinational dependency on xmean_ready.
  assign at_last     = (cnt_q == CNT_LAST);
  assign x_ready     = !(at_last && xmean_valid_q && !bus.xmean_ready);
  assign accept      = bus.x_valid && x_ready;
  assign last_accept = accept && at_last;

  // Block sum including the closing sample plus half an LSB; the top
  // DATA_WIDTH bits after the shift are the rounded mean. Full-scale input
  // lands exactly on 2^DATA_WIDTH-1, so no clipping is required.
  assign sum_last = acc_q + ACC_WIDTH'(bus.x_data) + ROUND_OFS;
  assign mean_w   = DATA_WIDTH'(sum_last >> BLOCK_SIZE_LOG);

  assign bus.x_ready     = x_ready;
  assign bus.xmean_valid = xmean_valid_q;
  assign bus.xmean_data  = xmean_data_q;

  // Next sample position within the block; wraps to 0 after the last one.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + BLOCK_SIZE_LOG'(1);
    end
  end

  // Next accumulator value; cleared when the block closes.
  always_comb begin
    acc_d = acc_q;
    if (last_accept) begin
      acc_d = '0;
    end else if (accept) begin
      acc_d = acc_q + ACC_WIDTH'(bus.x_data);
    end
  end

  // Next output register value: a fresh mean wins over a take, so a
  // same-cycle take and load keeps valid high with the new data.
  always_comb begin
    xmean_valid_d = xmean_valid_q;
    xmean_data_d  = xmean_data_q;
    if (last_accept) begin
      xmean_valid_d = 1'b1;
      xmean_data_d  = mean_w;
    end else if (xmean_valid_q && bus.xmean_ready) begin
      xmean_valid_d = 1'b0;
    end
  end

  // Sample counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Output mean register and its valid flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xmean_valid_q <= 1'b0;
      xmean_data_q  <= '0;
    end else begin
      xmean_valid_q <= xmean_valid_d;
      xmean_data_q  <= xmean_data_d;
    end
  end

endmodule

// File: tb/tb_block_mean_calc.sv
// Self-checking bench for block_mean_calc: directed ramp, saturation,
// rounding, backpressure and mid-block reset scenarios, then randomized
// valid/ready traffic, all scored against a block-sum reference model.
module tb_block_mean_calc;

  localparam int DW    = 16;
  localparam int BL    = 8;
  localparam int N     = 1 << BL;
  localparam int LIMIT = 2000;

  logic clk;
  logic rst;

  block_mean_calc_if #(.DATA_WIDTH(DW)) bus ();

  block_mean_calc #(
    .DATA_WIDTH    (DW),
    .BLOCK_SIZE_LOG(BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int rdy_mode    = 0;   // 0: always ready, 1: ready from cycle ready_on_at, 2: random
  int ready_on_at = 0;
  int vpct        = 100; // probability (%) of presenting a sample in a cycle

  // Reference model state
  longint         blk_sum = 0;
  int             blk_cnt = 0;
  logic [DW-1:0]  exp_q[$];
  logic [DW-1:0]  got_q[$];

  bit             acc_flag = 1'b0;
  bit             hold_prev = 1'b0;
  logic [DW-1:0]  hold_data = '0;
  int             acc_total = 0;
  int             stall_cnt = 0;
  int             first_stall_idx = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      0:       bus.xmean_ready = 1'b1;
      1:       bus.xmean_ready = (cyc >= ready_on_at);
      default: bus.xmean_ready = 1'($urandom_range(1, 0));
    endcase
  endtask

  // Present one sample (after optional random idle cycles) until accepted.
  task automatic send(input logic [DW-1:0] d);
    int guard;
    guard = 0;
    while (vpct < 100 && $urandom_range(99, 0) >= vpct) begin
      bus.x_valid = 1'b0;
      step();
    end
    bus.x_valid = 1'b1;
    bus.x_data  = d;
    do begin
      step();
      guard++;
    end while (!acc_flag && guard < LIMIT);
    if (!acc_flag) begin
      checks++;
      failures++;
      $display("FAIL send_timeout observed=no_accept expected=accept data=%0d", d);
    end
    bus.x_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected mean has been taken.
  task automatic drain();
    bus.x_valid = 1'b0;
    for (int k = 0; k < LIMIT && exp_q.size() != 0; k++) step();
    step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic chk_got(input string tag, input int idx, input logic [DW-1:0] e);
    chk(tag, (idx < got_q.size()) ? 32'(got_q[idx]) : 32'hFFFF_FFFF, 32'(e));
  endtask

  // ---------------- monitor / scoreboard ----------------
  // At the falling edge the inputs are stable for the next rising edge, so
  // both handshakes can be evaluated here and fed to the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_xmean_valid", 32'(bus.xmean_valid), 0);
      chk("rst_x_ready", 32'(bus.x_ready), 1);
      blk_sum   = 0;
      blk_cnt   = 0;
      exp_q.delete();
      hold_prev = 1'b0;
      acc_flag  = 1'b0;
    end else begin
      chk("x_ready", 32'(bus.x_ready),
          32'(!(blk_cnt == N - 1 && exp_q.size() != 0 && !bus.xmean_ready)));
      chk("xmean_valid", 32'(bus.xmean_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("xmean_data", 32'(bus.xmean_data), 32'(exp_q[0]));
      if (hold_prev) begin
        chk("hold_valid", 32'(bus.xmean_valid), 1);
        chk("hold_data", 32'(bus.xmean_data), 32'(hold_data));
      end
      hold_prev = bus.xmean_valid && !bus.xmean_ready;
      hold_data = bus.xmean_data;
      if (bus.x_valid && !bus.x_ready) begin
        stall_cnt++;
        if (first_stall_idx < 0) first_stall_idx = acc_total;
      end
      acc_flag = bus.x_valid && bus.x_ready;
      if (bus.xmean_valid && bus.xmean_ready) begin
        got_q.push_back(bus.xmean_data);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (acc_flag) begin
        acc_total++;
        blk_sum += longint'(bus.x_data);
        blk_cnt++;
        if (blk_cnt == N) begin
          exp_q.push_back(DW'((blk_sum + N / 2) / N));
          blk_sum = 0;
          blk_cnt = 0;
        end
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst             = 1'b0;
    bus.x_valid     = 1'b0;
    bus.x_data      = '0;
    bus.xmean_ready = 1'b1;
    repeat (3) step();
    chk("reset_xmean_data", 32'(bus.xmean_data), 0);
    chk("reset_xmean_valid", 32'(bus.xmean_valid), 0);
    chk("reset_x_ready", 32'(bus.x_ready), 1);
    rst = 1'b1;
    step();

    // Ramp 512.. with drain always ready
    got_q.delete();
    for (int i = 0; i < 3 * N; i++) send(DW'(512 + i));
    drain();
    chk("ramp_count", got_q.size(), 3);
    chk_got("ramp_mean0", 0, 640);
    chk_got("ramp_mean1", 1, 896);
    chk_got("ramp_mean2", 2, 1152);

    // Saturation
    got_q.delete();
    for (int i = 0; i < N; i++) send(16'hFFFF);
    drain();
    chk_got("sat_mean", 0, 16'hFFFF);

    // Rounding edges
    got_q.delete();
    for (int i = 0; i < N - 1; i++) send('0);
    send(DW'(128));
    for (int i = 0; i < N - 1; i++) send('0);
    send(DW'(127));
    drain();
    chk("round_count", got_q.size(), 2);
    chk_got("round_up_128", 0, 1);
    chk_got("round_down_127", 1, 0);

    // Backpressure: drain off for 600 cycles, continuous ramp input
    got_q.delete();
    acc_total       = 0;
    stall_cnt       = 0;
    first_stall_idx = -1;
    rdy_mode        = 1;
    ready_on_at     = cyc + 600;
    bus.xmean_ready = 1'b0;
    for (int i = 0; i < 3 * N; i++) send(DW'(512 + i));
    rdy_mode = 0;
    drain();
    chk("bp_first_stall_idx", first_stall_idx, 2 * N - 1);
    chk("bp_stalled", 32'(stall_cnt > 0), 1);
    chk("bp_count", got_q.size(), 3);
    chk_got("bp_mean0", 0, 640);
    chk_got("bp_mean1", 1, 896);
    chk_got("bp_mean2", 2, 1152);

    // Reset mid-block
    got_q.delete();
    for (int i = 0; i < 100; i++) send(DW'(1000));
    rst = 1'b0;
    step();
    step();
    chk("midrst_xmean_data", 32'(bus.xmean_data), 0);
    rst = 1'b1;
    step();
    for (int i = 0; i < N; i++) send(DW'(7));
    drain();
    chk("midrst_count", got_q.size(), 1);
    chk_got("midrst_mean", 0, 7);

    // Random valid/ready over 16 blocks
    got_q.delete();
    rdy_mode = 2;
    vpct     = 50;
    for (int i = 0; i < 16 * N; i++) send(DW'($urandom_range(65535, 0)));
    rdy_mode = 0;
    vpct     = 100;
    drain();
    chk("rand_count", got_q.size(), 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
